// File: rtl/axi_master_rd_pkg.sv
// rtl/axi_master_rd_pkg.sv - shared AR constants, response codes and FSM state type for the AXI read master
package axi_master_rd_pkg;

  localparam logic [2:0] SIZE_64B   = 3'd6;
  localparam logic [1:0] BURST_INCR = 2'd1;
  localparam logic [3:0] CACHE_NB   = 4'd3;
  localparam logic [1:0] OKAY       = 2'b00;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA,
    ST_DRAIN,
    ST_DISCARD
  } rd_state_t;

endpackage

// File: rtl/axi_master_rd_fifo.sv
// rtl/axi_master_rd_fifo.sv - read-beat buffer: sync FIFO with show-ahead output and look-ahead almost-full
module fifo_rd_buf #(
  parameter int WIDTH = 513,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full,
  output logic             afull,
  output logic             ovfl
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT  = (AW+1)'(DEPTH);
  localparam logic [AW:0] AFULL_CNT = FULL_CNT - (AW+1)'(2);
  localparam logic [AW:0] ONE       = (AW+1)'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      count, count_next;
  logic             do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rd_ptr];

  always_comb begin
    count_next = count;
    if (do_push && !do_pop)
      count_next = count + ONE;
    else if (do_pop && !do_push)
      count_next = count - ONE;
  end

  // Fewer than two entries free once this cycle's push/pop settle; lets a registered rready stop in time.
  assign afull = (count_next > AFULL_CNT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovfl   <= 1'b0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovfl   <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count_next;
      if (push && full) ovfl <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !clr) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/axi_master_rd.sv
// rtl/axi_master_rd.sv - AXI4 INCR-burst read master with local streaming output; AXI_RD_ID_CHECK_EN adds an RID check
module axi_master_rd
  import axi_master_rd_pkg::*;
#(
  parameter int ID_WIDTH     = 2,
  parameter int ADDR_WIDTH   = 64,
  parameter int DATA_WIDTH   = 512,
  parameter int ARUSER_WIDTH = 8,
  parameter int RUSER_WIDTH  = 1,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clear,
  input  logic [31:0]             i_snap_context,
  output logic [ID_WIDTH-1:0]     m_axi_arid,
  output logic [ADDR_WIDTH-1:0]   m_axi_araddr,
  output logic [7:0]              m_axi_arlen,
  output logic [2:0]              m_axi_arsize,
  output logic [1:0]              m_axi_arburst,
  output logic                    m_axi_arlock,
  output logic [3:0]              m_axi_arcache,
  output logic [2:0]              m_axi_arprot,
  output logic [3:0]              m_axi_arqos,
  output logic [3:0]              m_axi_arregion,
  output logic [ARUSER_WIDTH-1:0] m_axi_aruser,
  output logic                    m_axi_arvalid,
  input  logic                    m_axi_arready,
  input  logic [ID_WIDTH-1:0]     m_axi_rid,
  input  logic [DATA_WIDTH-1:0]   m_axi_rdata,
  input  logic [1:0]              m_axi_rresp,
  input  logic                    m_axi_rlast,
  input  logic [RUSER_WIDTH-1:0]  m_axi_ruser,
  input  logic                    m_axi_rvalid,
  output logic                    m_axi_rready,
  input  logic                    lcl_istart,
  input  logic [ADDR_WIDTH-1:0]   lcl_iaddr,
  input  logic [7:0]              lcl_inum,
  output logic                    lcl_ibusy,
  input  logic                    lcl_ordy,
  output logic                    lcl_dv,
  output logic [DATA_WIDTH-1:0]   lcl_dout,
  output logic                    lcl_olast,
  output logic [5:0]              status,
  output logic [3:0]              error
);

  rd_state_t       state;
  logic [7:0]      cnt;
  logic            clr_pend, rlast_err;
  logic [1:0]      rd_error;
  logic            r_hs, push, pop, beat_last;
  logic            f_empty, f_full, f_afull, f_ovfl;
  logic [DATA_WIDTH:0] f_dout;
  logic            unused_ok;

  assign m_axi_arid     = '0;
  assign m_axi_arsize   = SIZE_64B;
  assign m_axi_arburst  = BURST_INCR;
  assign m_axi_arlock   = 1'b0;
  assign m_axi_arcache  = CACHE_NB;
  assign m_axi_arprot   = 3'b000;
  assign m_axi_arqos    = 4'b0000;
  assign m_axi_arregion = 4'b0000;
  assign m_axi_aruser   = i_snap_context[ARUSER_WIDTH-1:0];

  assign r_hs      = m_axi_rvalid & m_axi_rready;
  assign push      = r_hs & (state == ST_DATA) & ~clear;
  assign pop       = ~f_empty & lcl_ordy & ~clear;
  assign beat_last = (cnt == m_axi_arlen);

  fifo_rd_buf #(.WIDTH(DATA_WIDTH + 1), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clear),
    .push  (push),
    .pop   (pop),
    .din   ({m_axi_rdata, beat_last}),
    .dout  (f_dout),
    .empty (f_empty),
    .full  (f_full),
    .afull (f_afull),
    .ovfl  (f_ovfl)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      m_axi_araddr  <= '0;
      m_axi_arlen   <= '0;
      m_axi_arvalid <= 1'b0;
      m_axi_rready  <= 1'b0;
      lcl_ibusy     <= 1'b0;
      cnt           <= '0;
      clr_pend      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (lcl_istart && !lcl_ibusy && !clear) begin
            m_axi_araddr  <= lcl_iaddr;
            m_axi_arlen   <= lcl_inum - 8'd1;
            m_axi_arvalid <= 1'b1;
            lcl_ibusy     <= 1'b1;
            state         <= ST_ADDR;
          end
        end
        ST_ADDR: begin
          // An abort here must still let the AR handshake finish; the burst it launches is then discarded.
          if (clear) clr_pend <= 1'b1;
          if (m_axi_arready) begin
            m_axi_arvalid <= 1'b0;
            cnt           <= '0;
            clr_pend      <= 1'b0;
            if (clear || clr_pend) begin
              state        <= ST_DISCARD;
              m_axi_rready <= 1'b1;
            end else begin
              state        <= ST_DATA;
              m_axi_rready <= ~f_afull;
            end
          end
        end
        ST_DATA: begin
          if (r_hs) cnt <= cnt + 8'd1;
          if (r_hs && m_axi_rlast) begin
            m_axi_rready <= 1'b0;
            if (clear) begin
              state     <= ST_IDLE;
              lcl_ibusy <= 1'b0;
            end else begin
              state <= ST_DRAIN;
            end
          end else if (clear) begin
            state        <= ST_DISCARD;
            m_axi_rready <= 1'b1;
          end else begin
            m_axi_rready <= ~f_afull;
          end
        end
        ST_DRAIN: begin
          if (clear || f_empty) begin
            state     <= ST_IDLE;
            lcl_ibusy <= 1'b0;
          end
        end
        ST_DISCARD: begin
          if (r_hs && m_axi_rlast) begin
            state        <= ST_IDLE;
            lcl_ibusy    <= 1'b0;
            m_axi_rready <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rlast_err <= 1'b0;
      rd_error  <= OKAY;
    end else if (clear) begin
      rlast_err <= 1'b0;
      rd_error  <= OKAY;
    end else if (push) begin
      if (m_axi_rlast != beat_last) rlast_err <= 1'b1;
      if (rd_error == OKAY && m_axi_rresp != OKAY) rd_error <= m_axi_rresp;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lcl_dv    <= 1'b0;
      lcl_olast <= 1'b0;
      lcl_dout  <= '0;
    end else begin
      lcl_dv    <= pop;
      lcl_olast <= pop & f_dout[0];
      if (pop) lcl_dout <= f_dout[DATA_WIDTH:1];
    end
  end

  assign status = {f_empty, f_full, f_ovfl, rlast_err, rd_error};

`ifdef AXI_RD_ID_CHECK_EN
  logic id_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      id_err <= 1'b0;
    else if (clear)
      id_err <= 1'b0;
    else if (push && m_axi_rid != m_axi_arid)
      id_err <= 1'b1;
  end

  assign error     = {f_ovfl | id_err, rlast_err, rd_error};
  assign unused_ok = ^{m_axi_ruser, i_snap_context[31:ARUSER_WIDTH]};
`else
  assign error     = {f_ovfl, rlast_err, rd_error};
  assign unused_ok = ^{m_axi_ruser, m_axi_rid, i_snap_context[31:ARUSER_WIDTH]};
`endif

endmodule

// File: tb/tb_axi_master_rd.sv
// tb/tb_axi_master_rd.sv - directed self-checking bench for axi_master_rd
module tb_axi_master_rd;

  localparam int DW = 512;
  localparam int AW = 64;
  typedef logic [DW-1:0] val_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          clear = 1'b0;
  logic [31:0]   i_snap_context = 32'hA5C3_5A7E;
  logic [1:0]    m_axi_arid;
  logic [AW-1:0] m_axi_araddr;
  logic [7:0]    m_axi_arlen;
  logic [2:0]    m_axi_arsize;
  logic [1:0]    m_axi_arburst;
  logic          m_axi_arlock;
  logic [3:0]    m_axi_arcache;
  logic [2:0]    m_axi_arprot;
  logic [3:0]    m_axi_arqos;
  logic [3:0]    m_axi_arregion;
  logic [7:0]    m_axi_aruser;
  logic          m_axi_arvalid;
  logic          m_axi_arready = 1'b0;
  logic [1:0]    m_axi_rid = 2'b00;
  logic [DW-1:0] m_axi_rdata = '0;
  logic [1:0]    m_axi_rresp = 2'b00;
  logic          m_axi_rlast = 1'b0;
  logic [0:0]    m_axi_ruser = 1'b0;
  logic          m_axi_rvalid = 1'b0;
  logic          m_axi_rready;
  logic          lcl_istart = 1'b0;
  logic [AW-1:0] lcl_iaddr = '0;
  logic [7:0]    lcl_inum = '0;
  logic          lcl_ibusy;
  logic          lcl_ordy = 1'b0;
  logic          lcl_dv;
  logic [DW-1:0] lcl_dout;
  logic          lcl_olast;
  logic [5:0]    status;
  logic [3:0]    error;

  int   n_checks = 0;
  int   n_fails = 0;
  int   hs_cnt = 0;
  val_t got_data[$];
  logic got_last[$];

  always #5 clk = ~clk;

  axi_master_rd dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .i_snap_context(i_snap_context),
    .m_axi_arid(m_axi_arid), .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
    .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst), .m_axi_arlock(m_axi_arlock),
    .m_axi_arcache(m_axi_arcache), .m_axi_arprot(m_axi_arprot), .m_axi_arqos(m_axi_arqos),
    .m_axi_arregion(m_axi_arregion), .m_axi_aruser(m_axi_aruser), .m_axi_arvalid(m_axi_arvalid),
    .m_axi_arready(m_axi_arready), .m_axi_rid(m_axi_rid), .m_axi_rdata(m_axi_rdata),
    .m_axi_rresp(m_axi_rresp), .m_axi_rlast(m_axi_rlast), .m_axi_ruser(m_axi_ruser),
    .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready), .lcl_istart(lcl_istart),
    .lcl_iaddr(lcl_iaddr), .lcl_inum(lcl_inum), .lcl_ibusy(lcl_ibusy), .lcl_ordy(lcl_ordy),
    .lcl_dv(lcl_dv), .lcl_dout(lcl_dout), .lcl_olast(lcl_olast), .status(status), .error(error)
  );

  task automatic check(input string tag, input val_t got, input val_t exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic val_t pat(input int seed, input int i);
    logic [31:0] w;
    w = 32'(seed * 65536 + i);
    return {16{w}};
  endfunction

  // Local-side monitor: samples just after the negedge, where bench drives have settled.
  always begin
    @(negedge clk);
    #1;
    if (lcl_dv) begin
      got_data.push_back(lcl_dout);
      got_last.push_back(lcl_olast);
    end
    if (m_axi_rvalid && m_axi_rready) hs_cnt++;
  end

  task automatic request(input logic [AW-1:0] addr, input logic [7:0] num);
    @(negedge clk);
    lcl_iaddr = addr;
    lcl_inum = num;
    lcl_istart = 1'b1;
    @(negedge clk);
    lcl_istart = 1'b0;
  endtask

  task automatic accept_ar(input int delay);
    int k = 0;
    while (!m_axi_arvalid && k < 100) begin
      @(negedge clk);
      k++;
    end
    check("ar_wait_timeout", val_t'(k >= 100), val_t'(0));
    repeat (delay) @(negedge clk);
    m_axi_arready = 1'b1;
    @(negedge clk);
    m_axi_arready = 1'b0;
  endtask

  task automatic send_beats(input int n, input int seed, input int last_idx,
                            input int err_idx, input logic [1:0] err_resp);
    for (int i = 0; i < n; i++) begin
      int k;
      m_axi_rvalid = 1'b1;
      m_axi_rdata = pat(seed, i);
      m_axi_rlast = (i == last_idx);
      m_axi_rresp = (i == err_idx) ? err_resp : 2'b00;
      k = 0;
      while (!m_axi_rready && k < 500) begin
        @(negedge clk);
        k++;
      end
      if (k >= 500) begin
        check("r_wait_timeout", val_t'(k), val_t'(0));
        break;
      end
      @(negedge clk);
    end
    m_axi_rvalid = 1'b0;
    m_axi_rlast = 1'b0;
    m_axi_rresp = 2'b00;
  endtask

  task automatic wait_beats(input int n);
    int k = 0;
    while (got_data.size() < n && k < 1000) begin
      @(negedge clk);
      k++;
    end
  endtask

  task automatic wait_idle(input string tag);
    int k = 0;
    while (lcl_ibusy && k < 100) begin
      @(negedge clk);
      k++;
    end
    check(tag, val_t'(lcl_ibusy), val_t'(0));
  endtask

  task automatic verify(input string tag, input int n, input int seed, input int last_idx);
    int errs = 0;
    check({tag, "_count"}, val_t'(got_data.size()), val_t'(n));
    for (int i = 0; i < n && i < got_data.size(); i++) begin
      if (got_data[i] !== pat(seed, i)) errs++;
      if (got_last[i] !== (i == last_idx)) errs++;
    end
    check({tag, "_beat_errs"}, val_t'(errs), val_t'(0));
    got_data.delete();
    got_last.delete();
  endtask

  task automatic pulse_clear();
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
  endtask

  initial begin
    #200us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int hs0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    check("rst_arvalid", val_t'(m_axi_arvalid), val_t'(0));
    check("rst_ibusy", val_t'(lcl_ibusy), val_t'(0));
    check("rst_rready", val_t'(m_axi_rready), val_t'(0));
    check("rst_dv", val_t'(lcl_dv), val_t'(0));
    check("rst_error", val_t'(error), val_t'(0));
    check("rst_status", val_t'(status), val_t'(6'b100000));
    check("ar_const", val_t'({m_axi_arid, m_axi_arsize, m_axi_arburst, m_axi_arlock,
                              m_axi_arcache, m_axi_arprot, m_axi_arqos, m_axi_arregion}),
          val_t'({2'd0, 3'd6, 2'd1, 1'b0, 4'd3, 3'd0, 4'd0, 4'd0}));
    check("ar_user", val_t'(m_axi_aruser), val_t'(8'h7E));

    // 4-beat burst, AR accepted after 3 cycles
    lcl_ordy = 1'b1;
    request(64'h1000, 8'd4);
    check("t1_arvalid", val_t'(m_axi_arvalid), val_t'(1));
    check("t1_ibusy", val_t'(lcl_ibusy), val_t'(1));
    repeat (3) @(negedge clk);
    check("t1_arvalid_held", val_t'(m_axi_arvalid), val_t'(1));
    check("t1_araddr", val_t'(m_axi_araddr), val_t'(64'h1000));
    check("t1_arlen", val_t'(m_axi_arlen), val_t'(8'd3));
    accept_ar(0);
    send_beats(4, 1, 3, -1, 2'b00);
    wait_beats(4);
    wait_idle("t1_idle");
    repeat (2) @(negedge clk);
    verify("t1", 4, 1, 3);
    check("t1_error", val_t'(error), val_t'(0));

    // inum=0 means 256 beats
    request(64'h2000, 8'd0);
    check("t2_arlen", val_t'(m_axi_arlen), val_t'(8'hFF));
    accept_ar(0);
    send_beats(256, 2, 255, -1, 2'b00);
    wait_beats(256);
    wait_idle("t2_idle");
    repeat (2) @(negedge clk);
    verify("t2", 256, 2, 255);
    check("t2_error", val_t'(error), val_t'(0));

    // consumer stalled for a 32-beat burst: backpressure at 15 stored beats
    lcl_ordy = 1'b0;
    request(64'h3000, 8'd32);
    check("t3_arlen", val_t'(m_axi_arlen), val_t'(8'd31));
    accept_ar(1);
    hs0 = hs_cnt;
    fork
      send_beats(32, 3, 31, -1, 2'b00);
      begin
        repeat (40) @(negedge clk);
        check("t3_stored", val_t'(hs_cnt - hs0), val_t'(15));
        check("t3_rready_low", val_t'(m_axi_rready), val_t'(0));
        check("t3_no_dv", val_t'(got_data.size()), val_t'(0));
        check("t3_status", val_t'(status[5:3]), val_t'(3'b000));
        lcl_ordy = 1'b1;
      end
    join
    wait_beats(32);
    wait_idle("t3_idle");
    repeat (2) @(negedge clk);
    verify("t3", 32, 3, 31);
    check("t3_error", val_t'(error), val_t'(0));

    // SLVERR on beat 2 of 4
    request(64'h4000, 8'd4);
    accept_ar(0);
    send_beats(4, 4, 3, 1, 2'b10);
    wait_beats(4);
    wait_idle("t4_idle");
    repeat (2) @(negedge clk);
    verify("t4", 4, 4, 3);
    check("t4_error", val_t'(error), val_t'(4'b0010));
    check("t4_status_rd", val_t'(status[1:0]), val_t'(2'b10));
    pulse_clear();
    check("t4_error_cleared", val_t'(error), val_t'(0));

    // early rlast on beat 3 of 5
    request(64'h5000, 8'd5);
    accept_ar(0);
    send_beats(3, 5, 2, -1, 2'b00);
    wait_beats(3);
    wait_idle("t5_idle");
    repeat (2) @(negedge clk);
    verify("t5", 3, 5, -1);
    check("t5_error", val_t'(error), val_t'(4'b0100));
    pulse_clear();
    check("t5_error_cleared", val_t'(error), val_t'(0));

    // clear after 2 of 8 beats, remaining beats discarded
    request(64'h6000, 8'd8);
    accept_ar(0);
    send_beats(2, 6, -1, -1, 2'b00);
    repeat (3) @(negedge clk);
    verify("t6_pre", 2, 6, -1);
    pulse_clear();
    check("t6_busy_discard", val_t'(lcl_ibusy), val_t'(1));
    send_beats(6, 16, 5, -1, 2'b00);
    wait_idle("t6_idle");
    repeat (3) @(negedge clk);
    check("t6_dropped", val_t'(got_data.size()), val_t'(0));
    check("t6_error", val_t'(error), val_t'(0));

    request(64'h7000, 8'd2);
    check("t7_araddr", val_t'(m_axi_araddr), val_t'(64'h7000));
    accept_ar(0);
    send_beats(2, 7, 1, -1, 2'b00);
    wait_beats(2);
    wait_idle("t7_idle");
    repeat (2) @(negedge clk);
    verify("t7", 2, 7, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
